ledg_blink_ctrl: RTL

Parametrised memory-mapped LED output controller with WIDTH independent channels. It sits on the processor's dbus/abus/wren slave bus alongside the other I/O devices. Beyond plain output latching, it adds atomic bit set/clear writes, a per-channel blink mask, and a programmable blink period driven by an internal prescaler counter. Software reads back its registers through a registered dbusout.

---
 rtl/ledg_blink_ctrl.sv | 80 ++++++++
 1 files changed

// File: rtl/ledg_blink_ctrl.sv
// ledg_blink_ctrl: memory-mapped LED controller with set/clear writes,
// a per-channel blink mask and a prescaler-driven blink phase.
module ledg_blink_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hF0000008,
    parameter int          WIDTH     = 8,
    parameter int          CNT_W     = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      dbus,
    input  logic [31:0]      abus,
    input  logic             wren,
    output logic [WIDTH-1:0] value,
    output logic [31:0]      dbusout
);
    localparam logic [31:0] A_DATA   = BASE_ADDR;
    localparam logic [31:0] A_BLINK  = BASE_ADDR + 32'd4;
    localparam logic [31:0] A_PERIOD = BASE_ADDR + 32'd8;
    localparam logic [31:0] A_SET    = BASE_ADDR + 32'd12;
    localparam logic [31:0] A_CLR    = BASE_ADDR + 32'd16;

    logic [WIDTH-1:0] data, blink;
    logic [CNT_W-1:0] period, cnt;
    logic             phase;
    logic [31:0]      rdata;
    logic             wr_data, wr_blink, wr_period, wr_set, wr_clr;

    assign wr_data   = wren && abus == A_DATA;
    assign wr_blink  = wren && abus == A_BLINK;
    assign wr_period = wren && abus == A_PERIOD;
    assign wr_set    = wren && abus == A_SET;
    assign wr_clr    = wren && abus == A_CLR;

    // Write data above WIDTH/CNT_W is intentionally discarded.
    logic unused;
    assign unused = ^dbus;

    always_comb begin
        rdata = abus == A_DATA   ? 32'(data)   :
                abus == A_BLINK  ? 32'(blink)  :
                abus == A_PERIOD ? 32'(period) : 32'd0;
    end

    assign value = data & (~blink | {WIDTH{phase}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data    <= '0;
            blink   <= '0;
            period  <= '0;
            cnt     <= '0;
            phase   <= 1'b1;
            dbusout <= '0;
        end else begin
            dbusout <= wren ? 32'd0 : rdata;
            if (wr_data)
                data <= dbus[WIDTH-1:0];
            else if (wr_set)
                data <= data | dbus[WIDTH-1:0];
            else if (wr_clr)
                data <= data & ~dbus[WIDTH-1:0];
            if (wr_blink)
                blink <= dbus[WIDTH-1:0];
            // A PERIOD write restarts the blink cycle in the lit phase.
            if (wr_period) begin
                period <= dbus[CNT_W-1:0];
                cnt    <= '0;
                phase  <= 1'b1;
            end else if (period == '0) begin
                cnt   <= '0;
                phase <= 1'b1;
            end else if (cnt == period - 1'b1) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
